matmul_result_streamer: RTL and testbench
=========================================

// Module: matmul_result_streamer
// PURPOSE
//  Downstream drain stage of the matrix-multiply top. On the done pulse it snapshots the
//  flattened M x N result vector (final_res) and streams it out one element per beat.
//  Streaming is row-major over a valid/ready handshake with row/col tags and a last flag.
//  The compute array is free to start the next product while the previous one drains.
// PARAMETERS
//  DATA_WIDTH  8  width of one result element
//  M           3  result rows
//  N           3  result columns
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             reset, asynchronous, active-low (0 = in reset)
//  start_i      in   1             done pulse from compute stage; capture res_i
//  res_i        in   M*N*DATA_WIDTH  element (m,n) at [(m*N+n)*DATA_WIDTH +: DATA_WIDTH]
//  busy_o       out  1             1 while a matrix is being streamed
//  out_valid_o  out  1             out_data_o/row/col/last valid
//  out_ready_i  in   1             consumer accepts beat when valid&&ready
//  out_data_o   out  DATA_WIDTH    current element
//  out_row_o    out  $clog2(M)     row index m of current element (min width 1)
//  out_col_o    out  $clog2(N)     column index n of current element (min width 1)
//  out_last_o   out  1             1 on element (M-1,N-1)
//  overrun_o    out  1             sticky: start_i arrived while a capture could not be taken
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, idx=0, all outputs 0, overrun_o=0; buffer contents don't-care.
//  - State IDLE: busy_o=0, out_valid_o=0. start_i=1 -> copy res_i into internal buffer, idx=0, go STREAM.
//  - State STREAM: busy_o=1, out_valid_o=1; outputs driven from buffer element idx (registered, row/col
//    counters kept alongside idx, no divider).
//  - Latency: start_i at edge t -> out_valid_o=1 with element (0,0) after edge t (first beat cycle t+1).
//  - Beat accepted when out_valid_o&&out_ready_i at a rising edge; idx advances, col wraps N-1->0 with row+1.
//  - Back-pressure: while valid&&!ready, data/row/col/last held stable; valid never deasserts mid-stream.
//  - Final beat (idx=M*N-1) accepted: go IDLE, out_valid_o=0 next cycle, idx=0.
//  - Simultaneous final-beat accept and start_i: new res_i captured, stay STREAM, idx=0, no bubble.
//  - start_i in STREAM without final-beat accept: ignored, buffer untouched, overrun_o<=1 (cleared only by reset).
//  - res_i sampled only on the capture edge; later changes on res_i have no effect on the stream.
//  - Reset asserted mid-stream: stream aborted immediately; no further beats after release until next start_i.
//  - M*N=1: single beat with out_last_o=1, row=col=0.
// CONFIGURATION
//  - Macro STREAMER_CHECKSUM_EN: when defined, adds output chk_o [DATA_WIDTH+$clog2(M*N)-1:0] (min
//    extra width 1): unsigned sum of all elements of the current matrix, accumulated on accepted
//    beats; equals the full-matrix sum while out_last_o=1, reset to 0 on each capture and on reset; never wraps.
//  - Without the macro: port chk_o and its accumulator are absent; all other behaviour identical.
// TESTING
//  1 res_i elements = 1..9 row-major, start_i 1 cycle, ready=1 -> 9 consecutive beats data 1..9,
//    (row,col)=(0,0)..(2,2), last only on data 9, busy_o 9 cycles, chk_o=45 on last beat (CHECKSUM_EN).
//  2 Same matrix, ready=0 for 3 cycles when data=4 presented -> data 4/row 1/col 0 held 4 cycles,
//    then 5..9 follow; total 12 valid cycles, no element lost or duplicated.
//  3 start_i again at beat 5 with res_i=all 8'hFF -> beats still 1..9, overrun_o=1 and stays 1.
//  4 start_i with res_i=10..18 in same cycle final beat (9) accepted -> next cycle data 10, valid
//    never drops; chk_o=126 on second last (CHECKSUM_EN); overrun_o=0.
//  5 rst=0 asynchronously while data=3 presented -> out_valid_o/busy_o 0 without clock edge;
//    after release no beats until new start_i, then stream restarts at (0,0).
//  6 Element values 8'hFF all nine -> data FF x9, chk_o=12'd2295 on last beat (no overflow).

Source files
------------

// File: rtl/matmul_result_streamer.sv
// Drain stage for the matrix-multiply result: snapshots M x N elements on start_i and streams them row-major.
// Optional running-sum output chk_o is enabled by defining STREAMER_CHECKSUM_EN.
module matmul_result_streamer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int M          = 3,
    parameter  int N          = 3,
    localparam int NE         = M * N,
    localparam int IW         = (NE > 1) ? $clog2(NE) : 1,
    localparam int RW         = (M > 1) ? $clog2(M) : 1,
    localparam int CW         = (N > 1) ? $clog2(N) : 1,
    localparam int SW         = DATA_WIDTH + IW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [NE*DATA_WIDTH-1:0]   res_i,
    output logic                       busy_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [RW-1:0]              out_row_o,
    output logic [CW-1:0]              out_col_o,
    output logic                       out_last_o,
`ifdef STREAMER_CHECKSUM_EN
    output logic [SW-1:0]              chk_o,
`endif
    output logic                       overrun_o
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_buf [NE];
    logic [IW-1:0]           r_idx;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_last;
    logic                    r_overrun;
    logic [SW-1:0]           r_chk;

    logic                    w_accept;
    logic                    w_final;
    logic                    w_capture;
    logic [IW-1:0]           w_idx_nx;
    logic [RW-1:0]           w_row_nx;
    logic [CW-1:0]           w_col_nx;
    logic                    w_last_nx;
    logic [DATA_WIDTH-1:0]   w_data_nx;

    // Handshake decode and next-element address; row/col step alongside idx so no divider is needed.
    always_comb begin
        w_accept  = r_valid & out_ready_i;
        w_final   = w_accept & r_last;
        w_capture = start_i & ((r_state == S_IDLE) | w_final);
        w_idx_nx  = r_idx + {{(IW-1){1'b0}}, 1'b1};
        w_last_nx = (w_idx_nx == IW'(NE - 1));
        w_data_nx = r_buf[w_idx_nx];
        if (r_col == CW'(N - 1)) begin
            w_col_nx = {CW{1'b0}};
            w_row_nx = r_row + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            w_col_nx = r_col + {{(CW-1){1'b0}}, 1'b1};
            w_row_nx = r_row;
        end
    end

    // Stream FSM: capture on start, advance on accepted beats, chain a new capture onto the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_idx     <= {IW{1'b0}};
            r_row     <= {RW{1'b0}};
            r_col     <= {CW{1'b0}};
            r_data    <= {DATA_WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
            r_chk     <= {SW{1'b0}};
        end else begin
            if (start_i && !w_capture) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                for (int e = 0; e < NE; e++) begin
                    r_buf[e] <= res_i[e*DATA_WIDTH +: DATA_WIDTH];
                end
                r_state <= S_STREAM;
                r_idx   <= {IW{1'b0}};
                r_row   <= {RW{1'b0}};
                r_col   <= {CW{1'b0}};
                r_data  <= res_i[0 +: DATA_WIDTH];
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
                r_last  <= (NE == 1);
                r_chk   <= SW'(res_i[0 +: DATA_WIDTH]);
            end else if (w_final) begin
                r_state <= S_IDLE;
                r_idx   <= {IW{1'b0}};
                r_row   <= {RW{1'b0}};
                r_col   <= {CW{1'b0}};
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_accept) begin
                r_idx   <= w_idx_nx;
                r_row   <= w_row_nx;
                r_col   <= w_col_nx;
                r_data  <= w_data_nx;
                r_last  <= w_last_nx;
                // Sum includes the element now presented, so it is the full total on the last beat.
                r_chk   <= r_chk + SW'(w_data_nx);
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign busy_o      = r_busy;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_row_o   = r_row;
    assign out_col_o   = r_col;
    assign out_last_o  = r_last;
    assign overrun_o   = r_overrun;
`ifdef STREAMER_CHECKSUM_EN
    assign chk_o       = r_chk;
`endif

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench for matmul_result_streamer: stimulus pushes expected beats, a negedge monitor checks them.
module tb_matmul_result_streamer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_i = 1'b0;
    logic [71:0]        res_i = '0;
    logic               busy_o;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic [7:0]         out_data_o;
    logic [1:0]         out_row_o;
    logic [1:0]         out_col_o;
    logic               out_last_o;
    logic               overrun_o;
`ifdef STREAMER_CHECKSUM_EN
    logic [11:0]        chk_o;
`endif

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
        logic [11:0] s;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;

    matmul_result_streamer #(.DATA_WIDTH(8), .M(3), .N(3)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .res_i(res_i),
        .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_row_o(out_row_o), .out_col_o(out_col_o),
        .out_last_o(out_last_o),
`ifdef STREAMER_CHECKSUM_EN
        .chk_o(chk_o),
`endif
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Monitor: compare every presented beat with the queue head; pop only when the beat is accepted.
    always @(negedge clk) begin
        if (rst) begin
            if (busy_o) busy_cnt++;
            if (out_valid_o) begin
                valid_cnt++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got data=%0h row=%0d col=%0d", out_data_o, out_row_o, out_col_o);
                end else begin
                    if ({out_data_o, out_row_o, out_col_o, out_last_o} !== {q[0].d, q[0].r, q[0].c, q[0].l}) begin
                        failures++;
                        $display("FAIL beat got d=%0h r=%0d c=%0d l=%0b want d=%0h r=%0d c=%0d l=%0b",
                                 out_data_o, out_row_o, out_col_o, out_last_o, q[0].d, q[0].r, q[0].c, q[0].l);
                    end
`ifdef STREAMER_CHECKSUM_EN
                    checks++;
                    if (chk_o !== q[0].s) begin
                        failures++;
                        $display("FAIL chk got=%0d want=%0d", chk_o, q[0].s);
                    end
`endif
                    if (out_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mk(input int base);
        logic [71:0] m;
        m = '0;
        for (int e = 0; e < 9; e++) m[e*8 +: 8] = 8'(base + e);
        return m;
    endfunction

    task automatic push_matrix(input logic [71:0] m);
        logic [11:0] sum;
        beat_t b;
        sum = 12'd0;
        for (int e = 0; e < 9; e++) begin
            sum  = sum + {4'd0, m[e*8 +: 8]};
            b.d  = m[e*8 +: 8];
            b.r  = 2'(e / 3);
            b.c  = 2'(e % 3);
            b.l  = (e == 8);
            b.s  = sum;
            q.push_back(b);
        end
    endtask

    task automatic issue(input logic [71:0] m, input bit expect_stream);
        if (expect_stream) push_matrix(m);
        start_i = 1'b1;
        res_i   = m;
        step();
        start_i = 1'b0;
        res_i   = '0;
    endtask

    task automatic wait_data(input logic [7:0] d);
        int n = 0;
        while (!(out_valid_o && out_data_o == d) && n < 100) begin
            step();
            n++;
        end
        check("wait_data_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy_o) && n < 200) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int v0;
        int b0;
        #3;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        step();
        rst = 1'b1;
        step();

        // 1: plain stream of 1..9
        v0 = valid_cnt; b0 = busy_cnt;
        issue(mk(1), 1'b1);
        drain();
        check("t1_valid_cycles", 32'(valid_cnt - v0), 32'd9);
        check("t1_busy_cycles", 32'(busy_cnt - b0), 32'd9);
        check("t1_idle_valid", 32'(out_valid_o), 32'd0);

        // 2: three-cycle stall on element 4
        v0 = valid_cnt;
        issue(mk(1), 1'b1);
        wait_data(8'd4);
        out_ready_i = 1'b0;
        step(); step(); step();
        out_ready_i = 1'b1;
        drain();
        check("t2_valid_cycles", 32'(valid_cnt - v0), 32'd12);

        // 4: back-to-back capture on the final beat
        issue(mk(1), 1'b1);
        wait_data(8'd9);
        issue(mk(10), 1'b1);
        check("t4_no_bubble_valid", 32'(out_valid_o), 32'd1);
        check("t4_first_data", 32'(out_data_o), 32'd10);
        drain();
        check("t4_overrun", 32'(overrun_o), 32'd0);

        // 3: start mid-stream is ignored and flags overrun
        issue(mk(1), 1'b1);
        wait_data(8'd5);
        issue({72{1'b1}}, 1'b0);
        check("t3_overrun_set", 32'(overrun_o), 32'd1);
        drain();
        check("t3_overrun_sticky", 32'(overrun_o), 32'd1);

        // 5: asynchronous reset mid-stream
        issue(mk(1), 1'b1);
        wait_data(8'd3);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid_o), 32'd0);
        check("t5_async_busy", 32'(busy_o), 32'd0);
        check("t5_overrun_clr", 32'(overrun_o), 32'd0);
        q.delete();
        step(); step();
        rst = 1'b1;
        repeat (5) step();
        check("t5_no_beats", 32'(out_valid_o), 32'd0);
        issue(mk(1), 1'b1);
        check("t5_restart_row", 32'(out_row_o), 32'd0);
        check("t5_restart_col", 32'(out_col_o), 32'd0);
        drain();

        // 6: all-FF matrix, checksum must not wrap
        issue({72{1'b1}}, 1'b1);
        drain();
        check("t6_queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
